// File: rtl/analyzer_pkg.sv
// Shared definitions for the pattern-analyzer event logging path.
//
// Contents:
//   REC_W, HDR_VALID_BIT, HDR_OVF_BIT, SEQ_W, DROP_MAX, TS_MAX : record layout constants
//   byte_sel_t : which byte of the head record the serializer returns next
//   make_rec() : packs header/drop/timestamp fields into one 32-bit record
//   rec_byte() : extracts one byte of a record, byte0 = most significant
//
// Record layout (byte0 is read first by the host):
//   [31:24] header  = {valid=1, ovf, seq[5:0]}
//   [23:16] drop_cnt
//   [15:8]  ts[15:8]
//   [7:0]   ts[7:0]
package analyzer_pkg;

    localparam int          REC_W         = 32;
    localparam int          HDR_VALID_BIT = 7;
    localparam int          HDR_OVF_BIT   = 6;
    localparam int          SEQ_W         = 6;
    localparam logic [7:0]  DROP_MAX      = 8'hFF;
    localparam logic [15:0] TS_MAX        = 16'hFFFF;

    typedef enum logic [1:0] {
        BYTE_HDR   = 2'd0,
        BYTE_DROP  = 2'd1,
        BYTE_TS_HI = 2'd2,
        BYTE_TS_LO = 2'd3
    } byte_sel_t;

    function automatic logic [REC_W-1:0] make_rec(
        input logic             ovf,
        input logic [SEQ_W-1:0] seq,
        input logic [7:0]       drop,
        input logic [15:0]      ts
    );
        logic [7:0] hdr;
        hdr                = 8'h00;
        hdr[SEQ_W-1:0]     = seq;
        hdr[HDR_OVF_BIT]   = ovf;
        hdr[HDR_VALID_BIT] = 1'b1;
        return {hdr, drop, ts};
    endfunction

    function automatic logic [7:0] rec_byte(
        input logic [REC_W-1:0] rec,
        input byte_sel_t        sel
    );
        logic [7:0] b;
        case (sel)
            BYTE_HDR:   b = rec[31:24];
            BYTE_DROP:  b = rec[23:16];
            BYTE_TS_HI: b = rec[15:8];
            default:    b = rec[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous single-clock FIFO holding event records.
//
// Ports:
//   CLK    in   clock, all state on posedge
//   RST_N  in   synchronous active-low reset
//   push   in   write din this cycle (ignored when full unless pop also succeeds)
//   pop    in   discard the head record this cycle (ignored when empty)
//   flush  in   empty the FIFO; wins over a same-cycle push/pop
//   din    in   record to write
//   dout   out  show-ahead head record (valid while empty==0)
//   level  out  number of stored records, registered
//   full   out  level==DEPTH, registered
//   empty  out  level==0, registered
//
// level/full/empty are all loaded from the same next-level value so the three
// outputs always agree with each other in every cycle.
module event_fifo
    import analyzer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = REC_W
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      level_nxt;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle: the freed slot is exactly the one the write pointer targets.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
            empty <= (level_nxt == '0);
        end
    end

    // Storage carries no reset; only slots behind the write pointer are ever read.
    always_ff @(posedge CLK) begin
        if (RST_N && !flush && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/match_event_log.sv
// Timestamped match-event logger between the pattern analyzer and the I2C
// slave transmitter.
//
// Ports:
//   CLK       in   clock, all state on posedge
//   RST_N     in   synchronous active-low reset
//   START     in   rising edge clears timestamp/FIFO/sequence and arms logging
//   RESULT    in   analyzer match flag; each rising edge while armed is one event
//   RD_REQ    in   byte read strobe from the I2C transmitter
//   RD_DATA   out  byte returned for the last RD_REQ (held between reads)
//   RD_VALID  out  1-cycle pulse marking RD_DATA as a real record byte
//   LEVEL     out  records currently stored
//   EMPTY     out  LEVEL==0
//   FULL      out  LEVEL==DEPTH
//   IRQ       out  high while records are waiting and logging is armed
//
// Read handshake: RD_REQ is sampled on a posedge; the answer appears on
// RD_DATA/RD_VALID after that same edge (one cycle latency). Requests may be
// issued every cycle. A request on an empty FIFO at a record boundary answers
// 8'h00 with RD_VALID low and does not advance the byte position. Four valid
// reads return byte0..byte3 of the head record; the fourth pops it.
module match_event_log
    import analyzer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic                    RESULT,
    input  logic                    RD_REQ,
    output logic [7:0]              RD_DATA,
    output logic                    RD_VALID,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    IRQ
);

    // Edge detectors
    logic start_q;
    logic result_q;
    logic rise;
    logic ev;

    // Logging state
    logic             armed;
    logic [TS_W-1:0]  ts;
    logic [SEQ_W-1:0] seq;
    logic [7:0]       drop_cnt;
    logic             ovf;

    // FIFO interface
    logic             push;
    logic             pop;
    logic             accept;
    logic             drop;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;

    // Byte serializer
    byte_sel_t  byte_idx;
    byte_sel_t  byte_idx_nxt;
    logic [7:0] rd_data_nxt;
    logic       rd_valid_nxt;

    assign rise = START & ~start_q;
    assign ev   = RESULT & ~result_q & armed;

    // A restart flushes the FIFO, so an event in the same cycle is discarded.
    assign push   = ev & ~rise;
    assign accept = push & (~fifo_full | pop);
    assign drop   = push & fifo_full & ~pop;

    // The record carries this cycle's timestamp and whatever drop information
    // has accumulated since the last accepted record.
    assign rec_in = make_rec(ovf, seq, drop_cnt, ts);

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .pop   (pop),
        .flush (rise),
        .din   (rec_in),
        .dout  (head),
        .level (LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign FULL  = fifo_full;
    assign EMPTY = fifo_empty;
    assign IRQ   = ~fifo_empty & armed;

    // Serializer next-state and read response. byte_idx only leaves BYTE_HDR
    // after a valid byte0 read, so a non-zero position always has a head record.
    always_comb begin
        byte_idx_nxt = byte_idx;
        rd_data_nxt  = RD_DATA;
        rd_valid_nxt = 1'b0;
        pop          = 1'b0;
        if (rise) begin
            // Any partially read record is gone with the flush.
            byte_idx_nxt = BYTE_HDR;
            if (RD_REQ) rd_data_nxt = 8'h00;
        end else if (RD_REQ) begin
            if (byte_idx == BYTE_HDR && fifo_empty) begin
                rd_data_nxt = 8'h00;
            end else begin
                rd_data_nxt  = rec_byte(head, byte_idx);
                rd_valid_nxt = 1'b1;
                case (byte_idx)
                    BYTE_HDR:   byte_idx_nxt = BYTE_DROP;
                    BYTE_DROP:  byte_idx_nxt = BYTE_TS_HI;
                    BYTE_TS_HI: byte_idx_nxt = BYTE_TS_LO;
                    default: begin
                        byte_idx_nxt = BYTE_HDR;
                        pop          = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            start_q  <= 1'b0;
            result_q <= 1'b0;
            armed    <= 1'b0;
            ts       <= '0;
            seq      <= '0;
            drop_cnt <= 8'h00;
            ovf      <= 1'b0;
            byte_idx <= BYTE_HDR;
            RD_DATA  <= 8'h00;
            RD_VALID <= 1'b0;
        end else begin
            start_q  <= START;
            result_q <= RESULT;
            byte_idx <= byte_idx_nxt;
            RD_DATA  <= rd_data_nxt;
            RD_VALID <= rd_valid_nxt;
            if (rise) begin
                armed <= 1'b1;
                ts    <= '0;
                seq   <= '0;
                ovf   <= 1'b0;
            end else begin
                if (armed && ts != TS_MAX) ts <= ts + TS_W'(1);
                if (accept) begin
                    seq      <= seq + SEQ_W'(1);
                    ovf      <= 1'b0;
                    drop_cnt <= 8'h00;
                end else if (drop) begin
                    ovf <= 1'b1;
                    if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_match_event_log.sv
module tb_match_event_log;

    localparam int DEPTH = 16;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic       RESULT;
    logic       RD_REQ;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic [4:0] LEVEL;
    logic       EMPTY;
    logic       FULL;
    logic       IRQ;

    int n_tests;
    int n_fail;

    match_event_log #(.DEPTH(DEPTH), .TS_W(16)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .RESULT   (RESULT),
        .RD_REQ   (RD_REQ),
        .RD_DATA  (RD_DATA),
        .RD_VALID (RD_VALID),
        .LEVEL    (LEVEL),
        .EMPTY    (EMPTY),
        .FULL     (FULL),
        .IRQ      (IRQ)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // Records kept as whole 32-bit words in a queue; byte position as an integer.
    logic [31:0] exp_q[$];
    int          m_ts, m_seq, m_drop, m_idx;
    bit          m_ovf, m_armed, m_start_q, m_res_q;
    logic [7:0]  m_data;
    bit          m_valid;

    task automatic model_reset();
        exp_q.delete();
        m_ts = 0; m_seq = 0; m_drop = 0; m_idx = 0;
        m_ovf = 0; m_armed = 0; m_start_q = 0; m_res_q = 0;
        m_data = 8'h00; m_valid = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input bit q);
        bit          rise, ev, popping;
        logic [31:0] rec, hd;
        if (!RST_N) begin
            model_reset();
            return;
        end
        rise    = s && !m_start_q;
        ev      = r && !m_res_q && m_armed;
        popping = 0;
        m_valid = 0;
        if (q) begin
            if (rise || (m_idx == 0 && exp_q.size() == 0)) begin
                m_data = 8'h00;
            end else begin
                hd      = exp_q[0];
                m_data  = 8'(hd >> (8 * (3 - m_idx)));
                m_valid = 1;
                if (m_idx == 3) begin
                    popping = 1;
                    m_idx   = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        rec = {1'b1, m_ovf, m_seq[5:0], m_drop[7:0], m_ts[15:0]};
        if (popping) void'(exp_q.pop_front());
        if (ev && !rise) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(rec);
                m_seq  = (m_seq + 1) % 64;
                m_ovf  = 0;
                m_drop = 0;
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (rise) begin
            exp_q.delete();
            m_ts = 0; m_armed = 1; m_seq = 0; m_ovf = 0; m_idx = 0;
        end else if (m_armed && m_ts < 65535) begin
            m_ts++;
        end
        m_start_q = s;
        m_res_q   = r;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    bit start_lvl;

    // One clock: drive inputs, let the edge happen, advance the model,
    // then compare every output 1 time unit after the edge.
    task automatic step(input bit r, input bit q);
        START  = start_lvl;
        RESULT = r;
        RD_REQ = q;
        @(posedge CLK);
        model_step(start_lvl, r, q);
        #1;
        check("rd_valid", {31'd0, RD_VALID}, {31'd0, m_valid});
        check("rd_data",  {24'd0, RD_DATA},  {24'd0, m_data});
        check("level",    {27'd0, LEVEL},    32'(exp_q.size()));
        check("empty",    {31'd0, EMPTY},    {31'd0, exp_q.size() == 0});
        check("full",     {31'd0, FULL},     {31'd0, exp_q.size() == DEPTH});
        check("irq",      {31'd0, IRQ},      {31'd0, (exp_q.size() != 0) && m_armed});
    endtask

    task automatic restart();
        start_lvl = 0;
        step(0, 0);
        start_lvl = 1;
        step(0, 0);
    endtask

    task automatic event_pulse();
        step(1, 0);
        step(0, 0);
    endtask

    task automatic read_byte(output logic [7:0] b);
        step(0, 1);
        b = RD_DATA;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] b0, b1, b2, b3;
        n_tests   = 0;
        n_fail    = 0;
        start_lvl = 0;
        RST_N     = 1'b0;
        START     = 1'b0;
        RESULT    = 1'b0;
        RD_REQ    = 1'b0;
        model_reset();

        // 1: reset dominates RESULT and RD_REQ
        repeat (3) step(1, 1);
        check("rst_empty",    {31'd0, EMPTY},    32'd1);
        check("rst_rd_valid", {31'd0, RD_VALID}, 32'd0);
        check("rst_irq",      {31'd0, IRQ},      32'd0);
        check("rst_level",    {27'd0, LEVEL},    32'd0);
        check("rst_rd_data",  {24'd0, RD_DATA},  32'd0);
        RST_N = 1'b1;
        step(0, 0);

        // 2: single event captured with ts=5
        restart();
        repeat (5) step(0, 0);
        event_pulse();
        check("single_irq", {31'd0, IRQ}, 32'd1);
        read_byte(b0); read_byte(b1); read_byte(b2); read_byte(b3);
        check("single_b0", {24'd0, b0}, 32'h80);
        check("single_b1", {24'd0, b1}, 32'h00);
        check("single_b2", {24'd0, b2}, 32'h00);
        check("single_b3", {24'd0, b3}, 32'h05);
        check("single_empty", {31'd0, EMPTY}, 32'd1);

        // 3: RESULT held high counts once
        repeat (10) step(1, 0);
        step(0, 0);
        check("held_level", {27'd0, LEVEL}, 32'd1);
        repeat (4) step(0, 1);

        // 4: overflow, drop info carried by the next accepted record
        restart();
        repeat (19) event_pulse();
        check("ovf_level", {27'd0, LEVEL}, 32'd16);
        check("ovf_full",  {31'd0, FULL},  32'd1);
        repeat (64) step(0, 1);
        check("ovf_drained", {31'd0, EMPTY}, 32'd1);
        event_pulse();
        read_byte(b0); read_byte(b1);
        check("ovf_b0", {24'd0, b0}, 32'hD0);
        check("ovf_b1", {24'd0, b1}, 32'h03);
        repeat (2) step(0, 1);

        // 5: push while full in the same cycle as the popping 4th-byte read
        restart();
        repeat (16) event_pulse();
        check("pp_full", {31'd0, FULL}, 32'd1);
        repeat (3) step(0, 1);
        step(1, 1);
        check("pp_level", {27'd0, LEVEL}, 32'd16);
        step(0, 0);
        check("pp_level2", {27'd0, LEVEL}, 32'd16);
        repeat (60) step(0, 1);
        read_byte(b0); read_byte(b1);
        check("pp_b0", {24'd0, b0}, 32'h90);
        check("pp_b1", {24'd0, b1}, 32'h00);
        repeat (2) step(0, 1);

        // 6: empty read, then restart in the middle of a record
        step(0, 1);
        check("emp_data",  {24'd0, RD_DATA},  32'h00);
        check("emp_valid", {31'd0, RD_VALID}, 32'd0);
        event_pulse();
        repeat (2) step(0, 1);
        restart();
        check("mid_empty", {31'd0, EMPTY}, 32'd1);
        event_pulse();
        read_byte(b0);
        check("mid_b0",    {24'd0, b0},       32'h80);
        check("mid_valid", {31'd0, RD_VALID}, 32'd1);
        repeat (3) step(0, 1);

        // 7: random traffic, fill-heavy then drain-heavy, with rare restarts
        restart();
        for (int i = 0; i < 2000; i++) begin
            int  rd_pct;
            bit  r, q, new_lvl;
            rd_pct  = (i < 700) ? 10 : ((i < 1400) ? 60 : 35);
            r       = ($urandom_range(0, 2) == 0);
            q       = ($urandom_range(0, 99) < rd_pct);
            new_lvl = start_lvl;
            if ($urandom_range(0, 199) == 0) new_lvl = !start_lvl;
            if (new_lvl && !start_lvl) q = 0;
            start_lvl = new_lvl;
            step(r, q);
        end
        start_lvl = 1;
        repeat (80) step(0, 1);

        // 8: timestamp saturates at FFFF
        restart();
        repeat (65540) step(0, 0);
        event_pulse();
        read_byte(b0); read_byte(b1); read_byte(b2); read_byte(b3);
        check("sat_b0", {24'd0, b0}, 32'h80);
        check("sat_b2", {24'd0, b2}, 32'hFF);
        check("sat_b3", {24'd0, b3}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
